// File: rtl/psw_bit_controller_pkg.sv
// Shared PSW definitions: write-op encodings, controller command codes, PSW bit indices.
package psw_bit_controller_pkg;

  localparam int SFR_OP_LEN = 3;
  localparam int PSW_CMD_W  = 3;

  localparam logic [SFR_OP_LEN-1:0] OP_PSW_NONE     = 3'b000;
  localparam logic [SFR_OP_LEN-1:0] OP_PSW_WR_BYTE  = 3'b001;
  localparam logic [SFR_OP_LEN-1:0] OP_PSW_WR_BIT   = 3'b010;
  localparam logic [SFR_OP_LEN-1:0] OP_PSW_WR_FLAGS = 3'b100;

  typedef enum logic [PSW_CMD_W-1:0] {
    PSW_CMD_RD_BIT   = 3'd0,
    PSW_CMD_SETB     = 3'd1,
    PSW_CMD_CLRB     = 3'd2,
    PSW_CMD_CPLB     = 3'd3,
    PSW_CMD_MOVB     = 3'd4,
    PSW_CMD_WR_FLAGS = 3'd5,
    PSW_CMD_WR_BYTE  = 3'd6,
    PSW_CMD_NOP      = 3'd7
  } psw_cmd_e;

  typedef enum logic [2:0] {
    PSW_P   = 3'd0,
    PSW_F1  = 3'd1,
    PSW_OV  = 3'd2,
    PSW_RS0 = 3'd3,
    PSW_RS1 = 3'd4,
    PSW_F0  = 3'd5,
    PSW_AC  = 3'd6,
    PSW_CY  = 3'd7
  } psw_bit_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_DONE
  } psw_state_e;

  // Bit-write payload understood by the PSW register: bit index in [3:1], value in [0].
  function automatic logic [7:0] bit_payload(input logic [2:0] addr, input logic value);
    return {4'b0000, addr, value};
  endfunction

endpackage

// File: rtl/psw_cmd_encode.sv
// Combinational builder of the PSW write payload and op from a latched command and PSW snapshot.
module psw_cmd_encode
  import psw_bit_controller_pkg::*;
(
  input  psw_cmd_e                cmd,
  input  logic [2:0]              addr,
  input  logic                    val,
  input  logic [2:0]              flags,
  input  logic [7:0]              data,
  input  logic [7:0]              snapshot,
  output logic [7:0]              wr_byte,
  output logic [SFR_OP_LEN-1:0]   wr_op,
  output logic                    err
);

  logic bit_value;
  logic addr_ro;

  assign addr_ro = (addr == PSW_P);

  always_comb begin
    bit_value = 1'b0;
    wr_byte   = 8'h00;
    wr_op     = OP_PSW_NONE;
    err       = 1'b0;
    case (cmd)
      PSW_CMD_SETB: bit_value = 1'b1;
      PSW_CMD_CPLB: bit_value = ~snapshot[addr];
      PSW_CMD_MOVB: bit_value = val;
      default:      bit_value = 1'b0;
    endcase
    case (cmd)
      // Parity (bit 0) is derived by the PSW register, so bit writes to it are refused.
      PSW_CMD_SETB, PSW_CMD_CLRB, PSW_CMD_CPLB, PSW_CMD_MOVB: begin
        wr_byte = bit_payload(addr, bit_value);
        if (addr_ro) err = 1'b1;
        else         wr_op = OP_PSW_WR_BIT;
      end
      PSW_CMD_WR_FLAGS: begin
        wr_byte = {5'b00000, flags};
        wr_op   = OP_PSW_WR_FLAGS;
      end
      PSW_CMD_WR_BYTE: begin
        wr_byte = data;
        wr_op   = OP_PSW_WR_BYTE;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/psw_bit_controller.sv
// PSW bit/flag command controller: snapshots the PSW, issues one write command
// (yielding to external writers), then reports completion and the resulting bit.
module psw_bit_controller
  import psw_bit_controller_pkg::*;
#(
  parameter int CMD_W = PSW_CMD_W
)
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [CMD_W-1:0]      i_cmd,
  input  logic [2:0]            i_addr,
  input  logic                  i_val,
  input  logic [2:0]            i_flags,
  input  logic [7:0]            i_data,
  input  logic [7:0]            i_psw,
  input  logic                  i_ext_busy,
  output logic [7:0]            o_byte,
  output logic [SFR_OP_LEN-1:0] o_op,
  output logic                  o_done,
  output logic                  o_rbit,
  output logic                  o_err
);

  psw_state_e            state;
  psw_cmd_e              cmd_q;
  logic [2:0]            addr_q;
  logic                  val_q;
  logic [2:0]            flags_q;
  logic [7:0]            data_q;
  logic [SFR_OP_LEN-1:0] op_q;
  logic                  err_q;

  logic [7:0]            enc_byte;
  logic [SFR_OP_LEN-1:0] enc_op;
  logic                  enc_err;

  psw_cmd_encode u_encode (
    .cmd      (cmd_q),
    .addr     (addr_q),
    .val      (val_q),
    .flags    (flags_q),
    .data     (data_q),
    .snapshot (i_psw),
    .wr_byte  (enc_byte),
    .wr_op    (enc_op),
    .err      (enc_err)
  );

  assign o_ready = (state == ST_IDLE);
  // Gated directly by state and busy so the op yields in the busy cycle and drops with async reset.
  assign o_op = (state == ST_ISSUE && !i_ext_busy) ? op_q : OP_PSW_NONE;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= ST_IDLE;
      cmd_q   <= PSW_CMD_NOP;
      addr_q  <= 3'd0;
      val_q   <= 1'b0;
      flags_q <= 3'd0;
      data_q  <= 8'h00;
      op_q    <= OP_PSW_NONE;
      err_q   <= 1'b0;
      o_byte  <= 8'h00;
      o_done  <= 1'b0;
      o_rbit  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            cmd_q   <= psw_cmd_e'(i_cmd[PSW_CMD_W-1:0]);
            addr_q  <= i_addr;
            val_q   <= i_val;
            flags_q <= i_flags;
            data_q  <= i_data;
            state   <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          o_byte <= enc_byte;
          op_q   <= enc_op;
          err_q  <= enc_err;
          state  <= (enc_op != OP_PSW_NONE) ? ST_ISSUE : ST_DONE;
        end
        ST_ISSUE: begin
          if (!i_ext_busy) state <= ST_SETTLE;
        end
        ST_SETTLE: state <= ST_DONE;
        ST_DONE: begin
          o_done <= 1'b1;
          o_err  <= err_q;
          o_rbit <= i_psw[addr_q];
          op_q   <= OP_PSW_NONE;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
